// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, ROM ids,
// default screen geometry and the RGB565 transparent key colour.
package sprite_blitter_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_WRITE,
      S_NEXT,
      S_FINISH
   } state_t;

   typedef enum logic [3:0] {
      ROM_ID_0, ROM_ID_1, ROM_ID_2,  ROM_ID_3,
      ROM_ID_4, ROM_ID_5, ROM_ID_6,  ROM_ID_7,
      ROM_ID_8, ROM_ID_9, ROM_ID_10, ROM_ID_11
   } rom_id_t;

   localparam int          SCREEN_W   = 240;
   localparam int          SCREEN_H   = 320;
   localparam logic [15:0] KEY_COLOUR = 16'hF81F;

   // Sums are done in int so origin+offset can never wrap before the compare.
   function automatic logic on_screen(input logic [7:0] x0, input logic [7:0] col,
                                      input logic [8:0] y0, input logic [8:0] row,
                                      input int sw, input int sh);
      return ((int'(x0) + int'(col)) < sw) && ((int'(y0) + int'(row)) < sh);
   endfunction

endpackage

// File: rtl/blit_counter.sv
// Row/column/linear-address walker for one sprite. The address is a plain
// incrementing counter (row*W+col without a multiplier) and wraps mod 2^16.
module blit_counter
   import sprite_blitter_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clr,
   input  logic        step,
   input  logic [7:0]  w,
   input  logic [8:0]  h,
   output logic [7:0]  col,
   output logic [8:0]  row,
   output logic [15:0] addr,
   output logic        last
);

   logic col_last;
   logic row_last;

   assign col_last = (col == w - 8'd1);
   assign row_last = (row == h - 9'd1);
   assign last     = col_last && row_last;

   // Advance one pixel per step; wrap the column into the next row.
   always_ff @(posedge clock) begin
      if (!reset) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (clr) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (step) begin
         addr <= addr + 16'd1;
         if (col_last) begin
            col <= '0;
            row <= row + 9'd1;
         end else begin
            col <= col + 8'd1;
         end
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite in ROM, clips against the screen and hands
// pixels to the LCD writer with a valid/ready handshake.
// Optional feature macro: TRANSPARENCY_EN (skip pixels equal to KEY_COLOUR).
module sprite_blitter #(
   parameter int          ROM_LATENCY = 2,
   parameter int          SCREEN_W    = sprite_blitter_pkg::SCREEN_W,
   parameter int          SCREEN_H    = sprite_blitter_pkg::SCREEN_H,
   parameter logic [15:0] KEY_COLOUR  = sprite_blitter_pkg::KEY_COLOUR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  spriteId,
   input  logic [7:0]  xOrigin,
   input  logic [8:0]  yOrigin,
   input  logic [7:0]  spriteW,
   input  logic [8:0]  spriteH,
   output logic [3:0]  ROMId,
   output logic [15:0] ROMAddr,
   input  logic [15:0] ReadROMOut,
   output logic        pixelWrite,
   input  logic        pixelReady,
   output logic [7:0]  pixelX,
   output logic [8:0]  pixelY,
   output logic [15:0] pixelData,
   output logic        busy,
   output logic        done
);
   import sprite_blitter_pkg::*;

   state_t                 state;
   logic [7:0]             x0;
   logic [8:0]             y0;
   logic [7:0]             w;
   logic [8:0]             h;
   logic [ROM_LATENCY-1:0] vld_pipe;
   logic [7:0]             col;
   logic [8:0]             row;
   logic                   last;
   logic                   drawable;
   logic                   cnt_clr;
   logic                   cnt_step;

   assign cnt_clr  = (state == S_IDLE) && start;
   assign cnt_step = (state == S_NEXT);

   blit_counter u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .step  (cnt_step),
      .w     (w),
      .h     (h),
      .col   (col),
      .row   (row),
      .addr  (ROMAddr),
      .last  (last)
   );

   // Clip test on the current pixel, optionally dropping the key colour.
   always_comb begin
      drawable = on_screen(x0, col, y0, row, SCREEN_W, SCREEN_H);
`ifdef TRANSPARENCY_EN
      if (ReadROMOut == KEY_COLOUR) drawable = 1'b0;
`endif
   end

   // Main FSM; all handshake/status outputs are registered here.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= S_IDLE;
         x0         <= '0;
         y0         <= '0;
         w          <= '0;
         h          <= '0;
         vld_pipe   <= '0;
         ROMId      <= '0;
         pixelWrite <= 1'b0;
         pixelX     <= '0;
         pixelY     <= '0;
         pixelData  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               ROMId <= spriteId;
               x0    <= xOrigin;
               y0    <= yOrigin;
               w     <= spriteW;
               h     <= spriteH;
               busy  <= 1'b1;
               state <= (spriteW == 8'd0 || spriteH == 9'd0) ? S_FINISH : S_FETCH;
            end
            S_FETCH: begin
               vld_pipe <= ROM_LATENCY'(1);
               state    <= S_WAIT;
            end
            // One-hot token walks vld_pipe; its top bit marks the last wait cycle.
            S_WAIT: begin
               vld_pipe <= vld_pipe << 1;
               if (vld_pipe[ROM_LATENCY-1]) begin
                  pixelData <= ReadROMOut;
                  pixelX    <= x0 + col;
                  pixelY    <= y0 + row;
                  if (drawable) begin
                     pixelWrite <= 1'b1;
                     state      <= S_WRITE;
                  end else begin
                     state <= S_NEXT;
                  end
               end
            end
            S_WRITE: if (pixelReady) begin
               pixelWrite <= 1'b0;
               state      <= S_NEXT;
            end
            S_NEXT:   state <= last ? S_FINISH : S_FETCH;
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a fixed-latency ROM model.
// Build with +define+TRANSPARENCY_EN to exercise the key-colour variant.
module tb_sprite_blitter;

   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  spriteId = '0;
   logic [7:0]  xOrigin = '0;
   logic [8:0]  yOrigin = '0;
   logic [7:0]  spriteW = '0;
   logic [8:0]  spriteH = '0;
   logic [3:0]  ROMId;
   logic [15:0] ROMAddr;
   logic [15:0] ReadROMOut;
   logic        pixelWrite;
   logic        pixelReady = 1'b1;
   logic [7:0]  pixelX;
   logic [8:0]  pixelY;
   logic [15:0] pixelData;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int ndone  = 0;
   int wx[$];
   int wy[$];
   int wd[$];
   logic key_en = 1'b0;
   logic [15:0] rp [LAT];

   sprite_blitter #(.ROM_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .start(start), .spriteId(spriteId),
      .xOrigin(xOrigin), .yOrigin(yOrigin), .spriteW(spriteW), .spriteH(spriteH),
      .ROMId(ROMId), .ROMAddr(ROMAddr), .ReadROMOut(ReadROMOut),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady), .pixelX(pixelX),
      .pixelY(pixelY), .pixelData(pixelData), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // ROM: pixel value encodes {id, addr}, optionally key colour at address 1.
   always @(posedge clock) begin
      rp[0] <= (key_en && ROMAddr == 16'd1) ? 16'hF81F : {ROMId, ROMAddr[11:0]};
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
   end
   assign ReadROMOut = rp[LAT-1];

   // Log accepted pixels and done pulses.
   always @(posedge clock) begin
      if (reset) begin
         if (pixelWrite && pixelReady) begin
            wx.push_back(int'(pixelX));
            wy.push_back(int'(pixelY));
            wd.push_back(int'(pixelData));
         end
         if (done) ndone <= ndone + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wx.delete(); wy.delete(); wd.delete();
   endtask

   task automatic pulse_start(input logic [3:0] id, input logic [7:0] x, input logic [8:0] y,
                              input logic [7:0] w, input logic [8:0] h);
      spriteId = id; xOrigin = x; yOrigin = y; spriteW = w; spriteH = h;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 1;
      while (!done && cyc < 300) begin
         @(negedge clock);
         cyc++;
      end
      check(tag, done, 1'b1);
      @(negedge clock);
   endtask

   task automatic wait_pw(input string tag);
      int n = 0;
      while (!pixelWrite && n < 100) begin
         @(negedge clock);
         n++;
      end
      check(tag, pixelWrite, 1'b1);
   endtask

   task automatic blit(input string tag, input logic [3:0] id, input logic [7:0] x,
                       input logic [8:0] y, input logic [7:0] w, input logic [8:0] h,
                       output int cyc);
      clear_log();
      pulse_start(id, x, y, w, h);
      wait_done(tag, cyc);
   endtask

   initial begin
      int cyc;
      int d0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_pw", pixelWrite, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_addr", ROMAddr, 16'd0);
      check("rst_id", ROMId, 4'd0);
      check("rst_data", pixelData, 16'd0);
      reset = 1'b1;
      @(negedge clock);

      // 2x2 sprite at origin
      d0 = ndone;
      blit("b1_done", 4'd5, 8'd0, 9'd0, 8'd2, 9'd2, cyc);
      check("b1_n", wx.size(), 4);
      if (wx.size() == 4) begin
         check("b1_x0", wx[0], 0); check("b1_y0", wy[0], 0); check("b1_d0", wd[0], 32'h5000);
         check("b1_x1", wx[1], 1); check("b1_y1", wy[1], 0); check("b1_d1", wd[1], 32'h5001);
         check("b1_x2", wx[2], 0); check("b1_y2", wy[2], 1); check("b1_d2", wd[2], 32'h5002);
         check("b1_x3", wx[3], 1); check("b1_y3", wy[3], 1); check("b1_d3", wd[3], 32'h5003);
      end
      check("b1_ndone", ndone - d0, 1);
      check("b1_busy", busy, 1'b0);

      // Right-edge clipping
      d0 = ndone;
      blit("clip_done", 4'd3, 8'd239, 9'd10, 8'd2, 9'd1, cyc);
      check("clip_n", wx.size(), 1);
      if (wx.size() == 1) begin
         check("clip_x", wx[0], 239); check("clip_y", wy[0], 10); check("clip_d", wd[0], 32'h3000);
      end
      check("clip_ndone", ndone - d0, 1);

      // Backpressure: outputs hold while pixelReady is low
      clear_log();
      pixelReady = 1'b0;
      pulse_start(4'd1, 8'd5, 9'd7, 8'd1, 9'd1);
      wait_pw("bp_pw");
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_hold_pw", pixelWrite, 1'b1);
         check("bp_hold_x", pixelX, 8'd5);
         check("bp_hold_y", pixelY, 9'd7);
         check("bp_hold_d", pixelData, 16'h1000);
      end
      pixelReady = 1'b1;
      wait_done("bp_done", cyc);
      check("bp_n", wx.size(), 1);
      if (wx.size() == 1) check("bp_d", wd[0], 32'h1000);

      // Key colour at address 1
      key_en = 1'b1;
      blit("key_done", 4'd2, 8'd0, 9'd0, 8'd3, 9'd1, cyc);
      key_en = 1'b0;
`ifdef TRANSPARENCY_EN
      check("key_n", wx.size(), 2);
      if (wx.size() == 2) begin
         check("key_x1", wx[1], 2); check("key_d1", wd[1], 32'h2002);
      end
`else
      check("key_n", wx.size(), 3);
      if (wx.size() == 3) begin
         check("key_x1", wx[1], 1); check("key_d1", wd[1], 32'hF81F);
      end
`endif

      // Reset during WRITE, then a fresh blit
      clear_log();
      d0 = ndone;
      pixelReady = 1'b0;
      pulse_start(4'd4, 8'd0, 9'd0, 8'd2, 9'd2);
      wait_pw("ab_pw");
      reset = 1'b0;
      @(negedge clock);
      check("ab_pw0", pixelWrite, 1'b0);
      check("ab_busy0", busy, 1'b0);
      check("ab_addr0", ROMAddr, 16'd0);
      check("ab_id0", ROMId, 4'd0);
      reset = 1'b1;
      pixelReady = 1'b1;
      repeat (10) @(negedge clock);
      check("ab_ndone", ndone - d0, 0);
      check("ab_nw", wx.size(), 0);
      blit("ab2_done", 4'd6, 8'd0, 9'd0, 8'd2, 9'd1, cyc);
      check("ab2_n", wx.size(), 2);
      if (wx.size() == 2) begin
         check("ab2_d0", wd[0], 32'h6000); check("ab2_d1", wd[1], 32'h6001);
      end

      // Zero-size sprites
      d0 = ndone;
      blit("w0_done", 4'd7, 8'd0, 9'd0, 8'd0, 9'd4, cyc);
      check("w0_lat", cyc, 2);
      check("w0_n", wx.size(), 0);
      blit("h0_done", 4'd7, 8'd0, 9'd0, 8'd4, 9'd0, cyc);
      check("h0_lat", cyc, 2);
      check("h0_ndone", ndone - d0, 2);

      // Start while busy is ignored
      clear_log();
      d0 = ndone;
      pixelReady = 1'b0;
      pulse_start(4'd1, 8'd0, 9'd0, 8'd1, 9'd1);
      wait_pw("ign_pw");
      pulse_start(4'd9, 8'd0, 9'd0, 8'd3, 9'd1);
      pixelReady = 1'b1;
      wait_done("ign_done", cyc);
      repeat (30) @(negedge clock);
      check("ign_n", wx.size(), 1);
      if (wx.size() == 1) check("ign_d", wd[0], 32'h1000);
      check("ign_ndone", ndone - d0, 1);
      check("ign_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter ROM_LATENCY, default 2, cycles from ROMAddr/ROMId change to matching ReadROMOut; legal range 1..4.
REQ-002 Parameter SCREEN_W, default 240, screen width in pixels.
REQ-003 Parameter SCREEN_H, default 320, screen height in pixels.
REQ-004 Parameter KEY_COLOUR, default 16'hF81F, RGB565 transparent colour.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that launches a blit; sampled only in IDLE.
REQ-008 spriteId  input  4  ROM select, latched on start.
REQ-009 xOrigin  input  8  screen X of sprite top-left, latched on start.
REQ-010 yOrigin  input  9  screen Y of sprite top-left, latched on start.
REQ-011 spriteW  input  8  sprite width in pixels, latched on start.
REQ-012 spriteH  input  9  sprite height in pixels, latched on start.
REQ-013 ROMId  output  4  ROM select to the ROM read mux.
REQ-014 ROMAddr  output  16  linear pixel address to the ROM read mux.
REQ-015 ReadROMOut  input  16  RGB565 pixel returned by the ROM read mux.
REQ-016 pixelWrite  output  1  pixel valid toward the LCD writer.
REQ-017 pixelReady  input  1  LCD writer accepts the pixel when high together with pixelWrite.
REQ-018 pixelX  output  8  pixel screen X.
REQ-019 pixelY  output  9  pixel screen Y.
REQ-020 pixelData  output  16  pixel RGB565 value.
REQ-021 busy  output  1  high in every state other than IDLE.
REQ-022 done  output  1  one-cycle pulse when a blit completes.

Function
REQ-023 The FSM SHALL have states IDLE, FETCH, WAIT, WRITE, NEXT and FINISH.
- IDLE->FETCH on start.
- IDLE->FINISH on start if spriteW==0 or spriteH==0.
REQ-024 FETCH SHALL drive ROMAddr=row*spriteW+col from an incrementing address counter (no multiplier) and ROMId=latched spriteId; both are held stable through WAIT.
REQ-025 WAIT SHALL last exactly ROM_LATENCY cycles, then capture ReadROMOut into pixelData.
- If the pixel is drawable: go to WRITE.
- Otherwise: go to NEXT.
REQ-026 A pixel is drawable if and only if xOrigin+col<SCREEN_W and yOrigin+row<SCREEN_H; the comparison uses widened arithmetic so the sum cannot wrap.
REQ-027 WRITE SHALL hold pixelWrite=1 with stable pixelX/pixelY/pixelData until the cycle where pixelReady=1, then go to NEXT.
REQ-028 NEXT SHALL increment col and the address counter.
- When col==spriteW-1: set col=0 and increment row.
- When row==spriteH-1 and col==spriteW-1: go to FINISH.
- Otherwise: go to FETCH.
REQ-029 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-030 A start pulse received while busy SHALL be ignored.
REQ-031 The address counter SHALL wrap modulo 2^16.

Reset
REQ-032 When reset==0 at a clock edge, the block SHALL enter IDLE and clear all outputs and counters to 0, including pixelWrite=0, done=0, busy=0, ROMId=0 and ROMAddr=0.
REQ-033 A reset mid-blit SHALL abandon the blit with no done pulse and no further pixelWrite.

Configuration
REQ-034 With TRANSPARENCY_EN defined, a pixel whose captured value equals KEY_COLOUR SHALL be treated as non-drawable: it is skipped via NEXT and never written.
REQ-035 Without TRANSPARENCY_EN, every in-screen pixel SHALL be written, including those equal to KEY_COLOUR.

Structure
REQ-036 A shared package SHALL hold the state enum, ROM ID constants (0..11), KEY_COLOUR, SCREEN_W and SCREEN_H.
REQ-037 One sub-module, blit_counter, SHALL hold the row/col/address counters and the end-of-sprite flag; the FSM stays in sprite_blitter.

Verification
REQ-038 start, spriteId=5, xOrigin=0, yOrigin=0, spriteW=2, spriteH=2, pixelReady=1 -> expected response:
- ROMAddr sequence 0,1,2,3.
- Four writes at (0,0),(1,0),(0,1),(1,1).
- One done pulse.
REQ-039 xOrigin=239, spriteW=2, spriteH=1 -> one write at X=239; column 1 clipped; done asserted.
REQ-040 pixelReady held 0 for 5 cycles during the first write -> pixelWrite and the outputs stay stable for those cycles; no pixel is lost.
REQ-041 With TRANSPARENCY_EN, a ROM model returning 16'hF81F at address 1 -> no write at col 1; without the macro -> write at col 1 with data F81F.
REQ-042 reset=0 asserted during WRITE, then a new start -> no done pulse for the aborted blit; the new blit runs from ROMAddr=0.
REQ-043 spriteW=0 -> done pulses 2 cycles after start with zero writes; a start issued while busy is ignored.
